// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register, 2-entry {pc, instr} queue toward decode,
// halt-opcode detection and branch/jump redirect with queue flush.
module fetch_controller #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [1:0]  state,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_HALTED = 2'b10;

    // Handshake: an entry leaves the queue on a rising edge where out_valid && out_ready
    // are both high; out_pc/out_instr hold steady while out_valid && !out_ready.

    logic [15:0] pc;
    logic [1:0]  st;
    logic [1:0]  count;
    logic [15:0] head_pc, head_instr;
    logic [15:0] tail_pc, tail_instr;
    logic [15:0] fcount;
    logic        pop;
    logic        push;
    logic        is_halt;
    logic        unused_redirect_lsb;

    assign imem_addr           = pc;
    assign state               = st;
    assign fetch_count         = fcount;
    assign out_valid           = (count != 2'd0);
    assign out_pc              = head_pc;
    assign out_instr           = head_instr;
    assign unused_redirect_lsb = redirect_pc[0];

    // Redirect squashes both queue movements in its cycle.
    assign pop     = out_valid && out_ready && !redirect_valid;
    assign push    = (st == S_RUN) && !redirect_valid && ((count != 2'd2) || pop);
    assign is_halt = (imem_instr == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= {RESET_PC[15:1], 1'b0};
            st         <= S_IDLE;
            count      <= 2'd0;
            fcount     <= 16'h0000;
            head_pc    <= 16'h0000;
            head_instr <= 16'h0000;
            tail_pc    <= 16'h0000;
            tail_instr <= 16'h0000;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[15:1], 1'b0};
            st    <= S_RUN;
            count <= 2'd0;
        end else begin
            case (st)
                S_IDLE:  if (start) st <= S_RUN;
                S_RUN:   if (push && is_halt) st <= S_HALTED;
                default: st <= st;
            endcase

            if (push) begin
                fcount <= fcount + 16'd1;
                if (!is_halt) pc <= pc + 16'd2;
            end

            if (push && pop) begin
                if (count == 2'd1) begin
                    head_pc    <= pc;
                    head_instr <= imem_instr;
                end else begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    tail_pc    <= pc;
                    tail_instr <= imem_instr;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_pc    <= pc;
                    head_instr <= imem_instr;
                end else begin
                    tail_pc    <= pc;
                    tail_instr <= imem_instr;
                end
                count <= count + 2'd1;
            end else if (pop) begin
                head_pc    <= tail_pc;
                head_instr <= tail_instr;
                count      <= count - 2'd1;
            end
        end
    end

endmodule
